// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a valid/ready fetch port, a 2-entry response FIFO,
// branch-redirect flush and in-band alignment/bounds error reporting.
module instr_fetch_mem #(
    parameter int                 INSTR_W      = 16,
    parameter int                 ADDR_W       = 16,
    parameter int                 MEM_BYTES    = 1024,
    parameter int                 STRIDE_BYTES = 4,
    parameter logic [INSTR_W-1:0] NOP_VALUE    = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      ld_we,
    input  logic [$clog2(MEM_BYTES/STRIDE_BYTES)-1:0] ld_idx,
    input  logic [INSTR_W-1:0]                        ld_data,
    input  logic                                      ld_done,
    output logic                                      ld_err,
    output logic                                      running,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [ADDR_W-1:0]                         req_addr,
    input  logic                                      flush,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [INSTR_W-1:0]                        rsp_instr,
    output logic [ADDR_W-1:0]                         rsp_addr,
    output logic                                      rsp_err,
    output logic                                      err_sticky
);
    // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
    // a response transfers on the rising edge where rsp_valid && rsp_ready, and the
    // rsp_* fields hold steady while rsp_valid=1 and rsp_ready=0.

    localparam int DEPTH = MEM_BYTES / STRIDE_BYTES;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(STRIDE_BYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STRIDE_BYTES - 1);
    localparam logic [ADDR_W:0]   SPAN_M1  = (ADDR_W+1)'(STRIDE_BYTES - 1);
    localparam logic [ADDR_W:0]   MEM_LIM  = (ADDR_W+1)'(MEM_BYTES);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [INSTR_W-1:0] mem [DEPTH];

    logic [INSTR_W-1:0] fifo_instr [2];
    logic [ADDR_W-1:0]  fifo_addr  [2];
    logic               fifo_err   [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         fifo_count;

    logic [ADDR_W:0]    req_end;
    logic               req_aligned, req_legal;
    logic [IDX_W-1:0]   req_idx;
    logic               push, pop, flush_run;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // Next state: BOOT is left once, and only a reset brings it back
    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && ld_done) state_d = ST_RUN;
    end

    // FSM outputs
    always_comb begin
        running   = (state_q == ST_RUN);
        ld_err    = (state_q == ST_RUN) && ld_we;
        req_ready = (state_q == ST_RUN) && !flush && (fifo_count < 2'd2);
    end

    // Load port; memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (state_q == ST_BOOT && ld_we) mem[ld_idx] <= ld_data;
    end

    // End address is one bit wider than req_addr so high addresses cannot wrap into range
    assign req_end     = {1'b0, req_addr} + SPAN_M1;
    assign req_aligned = (req_addr & OFF_MASK) == '0;
    assign req_legal   = req_aligned && (req_end < MEM_LIM);
    assign req_idx     = IDX_W'(req_addr >> OFF_W);

    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign flush_run = flush && (state_q == ST_RUN);

    // The synchronous read lands directly in the FIFO slot, giving one-cycle latency
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= req_legal ? mem[req_idx] : NOP_VALUE;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_err[wr_ptr]   <= !req_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            err_sticky <= 1'b0;
        end else begin
            if (push && !req_legal) err_sticky <= 1'b1;
            if (flush_run) begin
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                fifo_count <= 2'd0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 2'd1;
                    2'b01:   fifo_count <= fifo_count - 2'd1;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // Response fields read zero whenever nothing is buffered
    always_comb begin
        rsp_valid = (fifo_count != 2'd0);
        rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : '0;
        rsp_addr  = rsp_valid ? fifo_addr[rd_ptr]  : '0;
        rsp_err   = rsp_valid ? fifo_err[rd_ptr]   : 1'b0;
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: boot load, latency, errors, backpressure,
// flush, load-after-run and asynchronous reset, with an in-order response scoreboard.
module tb_instr_fetch_mem;
    localparam int EW = 33;  // {err, addr[15:0], instr[15:0]}

    logic        clk;
    logic        rst_n;
    logic        ld_we;
    logic [7:0]  ld_idx;
    logic [15:0] ld_data;
    logic        ld_done;
    logic        ld_err;
    logic        running;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_instr;
    logic [15:0] rsp_addr;
    logic        rsp_err;
    logic        err_sticky;

    int checks = 0;
    int failures = 0;

    logic [15:0]   ref_mem [256];
    logic [EW-1:0] exp_q[$];

    instr_fetch_mem dut (
        .clk(clk), .rst_n(rst_n),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data), .ld_done(ld_done),
        .ld_err(ld_err), .running(running),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .err_sticky(err_sticky)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: legality and contents from the bench's own copy of the loaded image
    function automatic logic exp_err_of(input logic [15:0] a);
        int ai;
        ai = int'(a);
        return !((ai % 4 == 0) && (ai + 3 < 1024));
    endfunction

    function automatic logic [15:0] exp_word_of(input logic [15:0] a);
        int ai;
        ai = int'(a);
        if (exp_err_of(a)) return 16'h0000;
        return ref_mem[ai / 4];
    endfunction

    // Scoreboard: pop on response handshake, push on request handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("sb_instr", rsp_instr, e[15:0]);
                    check("sb_addr", rsp_addr, e[31:16]);
                    check("sb_err", rsp_err, e[32]);
                end
            end
            if (req_valid && req_ready)
                exp_q.push_back({exp_err_of(req_addr), req_addr, exp_word_of(req_addr)});
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge
    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch_one(input logic [15:0] a);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_accept", req_ready, 1);
        at_pos();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
        at_pos();
    endtask

    initial begin
        rst_n = 1'b0; ld_we = 1'b0; ld_idx = '0; ld_data = '0; ld_done = 1'b0;
        req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_instr", rsp_instr, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_ld_err", ld_err, 0);
        check("rst_running", running, 0);

        // Boot load; the last write shares its cycle with ld_done
        at_pos();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ld_we   = 1'b1;
            ld_idx  = 8'(i);
            ld_data = (i == 0) ? 16'h1234 : (i == 1) ? 16'hABCD : 16'($urandom_range(0, 65535));
            ref_mem[i] = ld_data;
            req_valid = 1'b1;
            req_addr  = 16'h0000;
            at_pos();
        end
        check("boot_req_ready", req_ready, 0);
        ld_idx  = 8'd255;
        ld_data = 16'($urandom_range(0, 65535));
        ref_mem[255] = ld_data;
        ld_done = 1'b1;
        req_valid = 1'b0;
        at_pos();
        ld_we = 1'b0;
        ld_done = 1'b0;
        @(negedge clk);
        check("run_running", running, 1);

        // Back-to-back fetches at full rate
        at_pos();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'd0;
        @(negedge clk);
        check("b2b_ready0", req_ready, 1);
        at_pos();
        req_addr = 16'd4;
        @(negedge clk);
        check("b2b_valid_n1", rsp_valid, 1);
        check("b2b_instr_n1", rsp_instr, 16'h1234);
        check("b2b_err_n1", rsp_err, 0);
        check("b2b_ready1", req_ready, 1);
        at_pos();
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid_n2", rsp_valid, 1);
        check("b2b_instr_n2", rsp_instr, 16'hABCD);
        drain();
        check("sticky_clear", err_sticky, 0);

        // Misaligned and out-of-bounds addresses
        fetch_one(16'd2);
        @(negedge clk);
        check("mis_err", rsp_err, 1);
        check("mis_instr", rsp_instr, 16'h0000);
        check("mis_sticky", err_sticky, 1);
        drain();
        fetch_one(16'd1020);
        drain();
        fetch_one(16'd1024);
        drain();
        fetch_one(16'hFFFC);
        drain();
        fetch_one(16'd20);
        drain();
        check("sticky_hold", err_sticky, 1);

        // Backpressure: two accepted, third stalls, head holds still
        at_pos();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'd8;
        @(negedge clk);
        check("bp_ready_a", req_ready, 1);
        at_pos();
        req_addr = 16'd12;
        @(negedge clk);
        check("bp_ready_b", req_ready, 1);
        at_pos();
        req_addr = 16'd16;
        @(negedge clk);
        check("bp_ready_full", req_ready, 0);
        check("bp_head_addr", rsp_addr, 16'd8);
        at_pos();
        @(negedge clk);
        check("bp_ready_full2", req_ready, 0);
        check("bp_hold_addr", rsp_addr, 16'd8);
        check("bp_hold_instr", rsp_instr, ref_mem[2]);
        at_pos();
        rsp_ready = 1'b1;
        @(negedge clk);
        at_pos();
        @(negedge clk);
        check("bp_ready_back", req_ready, 1);
        at_pos();
        req_valid = 1'b0;
        drain();

        // Flush with two responses buffered
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'd0;
        @(negedge clk);
        at_pos();
        req_addr = 16'd4;
        @(negedge clk);
        at_pos();
        req_addr = 16'd20;
        flush    = 1'b1;
        @(negedge clk);
        check("fl_req_ready", req_ready, 0);
        check("fl_valid_same", rsp_valid, 1);
        at_pos();
        flush     = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("fl_valid_next", rsp_valid, 0);
        fetch_one(16'd8);
        @(negedge clk);
        check("fl_post_instr", rsp_instr, ref_mem[2]);
        check("fl_post_addr", rsp_addr, 16'd8);
        drain();

        // Load attempt while running is rejected
        ld_we   = 1'b1;
        ld_idx  = 8'd3;
        ld_data = ~ref_mem[3];
        @(negedge clk);
        check("ldrun_err", ld_err, 1);
        at_pos();
        ld_we = 1'b0;
        @(negedge clk);
        check("ldrun_err_drop", ld_err, 0);
        at_pos();
        fetch_one(16'd12);
        drain();

        // Asynchronous reset between edges while a response is buffered
        rsp_ready = 1'b0;
        fetch_one(16'd16);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_rsp_valid", rsp_valid, 0);
        check("ar_rsp_instr", rsp_instr, 0);
        check("ar_rsp_addr", rsp_addr, 0);
        check("ar_running", running, 0);
        check("ar_req_ready", req_ready, 0);
        check("ar_err_sticky", err_sticky, 0);
        exp_q.delete();
        at_pos();
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'd4;
        @(negedge clk);
        check("ar_boot_ready", req_ready, 0);
        check("ar_boot_running", running, 0);
        at_pos();
        ld_done = 1'b1;
        at_pos();
        ld_done = 1'b0;
        @(negedge clk);
        check("ar_run_running", running, 1);
        check("ar_run_ready", req_ready, 1);
        at_pos();
        req_valid = 1'b0;
        @(negedge clk);
        check("ar_mem_kept", rsp_instr, 16'hABCD);
        drain();
        fetch_one(16'd1020);
        drain();

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
